// File: rtl/phase_accumulator_if.sv
// Configuration handshake and lookup-side outputs of the DDS phase generator.
// The controller side uses master; the phase_accumulator uses slave.
interface phase_accumulator_if #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 8
);
  logic               run;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [ACC_W-1:0]   cfg_ftw;
  logic [PHASE_W-1:0] cfg_poff;
  logic [1:0]         cfg_select;
  logic [PHASE_W-1:0] phase_out;
  logic               en_out;
  logic [1:0]         select_out;
  logic               wrap_pulse;

  modport master (
    output run, cfg_valid, cfg_ftw, cfg_poff, cfg_select,
    input  cfg_ready, phase_out, en_out, select_out, wrap_pulse
  );

  modport slave (
    input  run, cfg_valid, cfg_ftw, cfg_poff, cfg_select,
    output cfg_ready, phase_out, en_out, select_out, wrap_pulse
  );
endinterface

// File: rtl/phase_accumulator.sv
// DDS phase generator: accumulates a tuning word and feeds the lookup stage.
// Configuration changes, starts and stops take effect only at period boundaries.
module phase_accumulator #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  phase_accumulator_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  logic [1:0]         state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic               carry;
  logic [ACC_W-1:0]   ftw_a, ftw_s;
  logic [PHASE_W-1:0] poff_a, poff_s;
  logic [1:0]         sel_a, sel_s;
  logic               pending;
  logic               wrap_q;
  logic               active;
  logic               commit;
  logic               accept;

  always_comb begin
    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    {carry, acc_next} = {1'b0, acc} + {1'b0, ftw_a};
    active = (state != ST_IDLE);
    // In IDLE the shadow is taken immediately; while running only at a wrap.
    commit = pending & (~active | carry);
    accept = bus.cfg_valid & ~pending;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      ftw_a   <= '0;
      poff_a  <= '0;
      sel_a   <= '0;
      ftw_s   <= '0;
      poff_s  <= '0;
      sel_s   <= '0;
      pending <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= active & carry;

      // commit needs pending=1 and accept needs pending=0, so they never collide
      if (commit) begin
        ftw_a   <= ftw_s;
        poff_a  <= poff_s;
        sel_a   <= sel_s;
        pending <= 1'b0;
      end else if (accept) begin
        ftw_s   <= bus.cfg_ftw;
        poff_s  <= bus.cfg_poff;
        sel_s   <= bus.cfg_select;
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          acc <= '0;
          if (bus.run) state <= ST_RUN;
        end
        ST_RUN: begin
          acc <= acc_next;
          if (!bus.run) state <= ST_STOPPING;
        end
        ST_STOPPING: begin
          if (bus.run) begin
            acc   <= acc_next;
            state <= ST_RUN;
          end else if (carry || (ftw_a == '0)) begin
            // a zero tuning word never wraps, so stop right away
            acc   <= '0;
            state <= ST_IDLE;
          end else begin
            acc <= acc_next;
          end
        end
        default: begin
          acc   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.phase_out  = active ? (acc[ACC_W-1 -: PHASE_W] + poff_a) : '0;
  assign bus.en_out     = active;
  assign bus.select_out = sel_a;
  assign bus.wrap_pulse = wrap_q;
  assign bus.cfg_ready  = ~pending;

endmodule

// File: tb/tb_phase_accumulator.sv
// Scoreboard bench for phase_accumulator: a behavioural model predicts every
// cycle's outputs into a queue, and a monitor compares them on the falling edge.
module tb_phase_accumulator;
  localparam int    ACC_W   = 24;
  localparam int    PHASE_W = 8;
  localparam longint MOD    = longint'(1) << ACC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_accumulator_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) bus ();

  phase_accumulator #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] phase;
    logic       en;
    logic [1:0] sel;
    logic       wrap;
    logic       ready;
  } obs_t;

  typedef enum int {M_OFF, M_ON, M_DRAIN} mode_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: generator mode, phase accumulator as plain integer,
  // active and buffered configuration.
  mode_t  m_mode = M_OFF;
  longint m_acc  = 0;
  longint a_ftw  = 0, s_ftw = 0;
  int     a_poff = 0, s_poff = 0;
  int     a_sel  = 0, s_sel = 0;
  bit     m_pend = 0;
  bit     m_wrap = 0;

  function automatic obs_t m_outputs();
    obs_t o;
    o.en    = (m_mode != M_OFF);
    o.phase = o.en ? 8'(((m_acc >> (ACC_W - PHASE_W)) + a_poff) % 256) : 8'h00;
    o.sel   = 2'(a_sel);
    o.wrap  = m_wrap;
    o.ready = !m_pend;
    return o;
  endfunction

  always @(posedge clk) begin : model
    bit     take;
    longint sum;
    longint old_ftw;
    take = bus.cfg_valid && !m_pend;
    if (rst) begin
      m_mode = M_OFF; m_acc = 0; m_wrap = 0; m_pend = 0;
      a_ftw = 0; a_poff = 0; a_sel = 0;
      s_ftw = 0; s_poff = 0; s_sel = 0;
    end else begin
      m_wrap = 0;
      if (m_mode == M_OFF) begin
        if (m_pend) begin
          a_ftw = s_ftw; a_poff = s_poff; a_sel = s_sel; m_pend = 0;
        end
        m_acc = 0;
        if (bus.run) m_mode = M_ON;
      end else begin
        old_ftw = a_ftw;
        sum     = m_acc + a_ftw;
        m_wrap  = (sum >= MOD);
        m_acc   = sum % MOD;
        if (m_wrap && m_pend) begin
          a_ftw = s_ftw; a_poff = s_poff; a_sel = s_sel; m_pend = 0;
        end
        if (m_mode == M_ON) begin
          if (!bus.run) m_mode = M_DRAIN;
        end else if (bus.run) begin
          m_mode = M_ON;
        end else if (m_wrap || old_ftw == 0) begin
          m_mode = M_OFF;
          m_acc  = 0;
        end
      end
      if (take) begin
        s_ftw  = longint'(bus.cfg_ftw);
        s_poff = int'(bus.cfg_poff);
        s_sel  = int'(bus.cfg_select);
        m_pend = 1;
      end
    end
    exp_q.push_back(m_outputs());
  end

  always @(negedge clk) begin : monitor
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.phase = bus.phase_out;
      a.en    = bus.en_out;
      a.sel   = bus.select_out;
      a.wrap  = bus.wrap_pulse;
      a.ready = bus.cfg_ready;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got phase=%h en=%b sel=%b wrap=%b ready=%b expected phase=%h en=%b sel=%b wrap=%b ready=%b",
                 $time, a.phase, a.en, a.sel, a.wrap, a.ready, e.phase, e.en, e.sel, e.wrap, e.ready);
      end
    end
  end

  task automatic check(input bit ok, input string tag);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s t=%0t", tag, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic offer(input logic [ACC_W-1:0] ftw, input logic [7:0] poff, input logic [1:0] sel);
    bus.cfg_valid  = 1'b1;
    bus.cfg_ftw    = ftw;
    bus.cfg_poff   = poff;
    bus.cfg_select = sel;
    tick();
    bus.cfg_valid  = 1'b0;
  endtask

  task automatic wait_phase(input int val, input int budget, input string tag);
    obs_t o;
    checks++;
    for (int i = 0; i < budget; i++) begin
      o = m_outputs();
      if (o.en && o.phase == 8'(val)) return;
      tick();
    end
    errors++;
    $display("FAIL %s timeout: phase %h not reached within %0d cycles", tag, val, budget);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    checks++;
    for (int i = 0; i < budget; i++) begin
      if (m_mode == M_OFF) return;
      tick();
    end
    errors++;
    $display("FAIL %s timeout: generator still running after %0d cycles", tag, budget);
  endtask

  task automatic wait_commit(input int budget, input string tag);
    checks++;
    for (int i = 0; i < budget; i++) begin
      if (!m_pend) return;
      tick();
    end
    errors++;
    $display("FAIL %s timeout: configuration still pending after %0d cycles", tag, budget);
  endtask

  initial begin
    // reset held with run and an offer present: nothing may be taken
    rst            = 1'b1;
    bus.run        = 1'b1;
    bus.cfg_valid  = 1'b1;
    bus.cfg_ftw    = 24'h123456;
    bus.cfg_poff   = 8'h5A;
    bus.cfg_select = 2'b01;
    tick(2);
    rst           = 1'b0;
    bus.run       = 1'b0;
    bus.cfg_valid = 1'b0;
    tick(2);
    check(bus.phase_out === 8'h00, "reset_phase");
    check(bus.en_out === 1'b0, "reset_en");
    check(bus.select_out === 2'b00, "reset_select");
    check(bus.wrap_pulse === 1'b0, "reset_wrap");
    check(bus.cfg_ready === 1'b1, "reset_ready");

    // basic run: phase ramps 0..255 with a wrap every 256 cycles
    offer(24'h010000, 8'h00, 2'b11);
    tick(2);
    check(bus.cfg_ready === 1'b1, "idle_commit_ready");
    check(bus.select_out === 2'b11, "idle_commit_select");
    bus.run = 1'b1;
    tick(600);

    // retune mid-period: takes effect exactly at the wrap
    wait_phase(8'h40, 300, "retune_align");
    offer(24'h020000, 8'h80, 2'b10);
    check(bus.cfg_ready === 1'b0, "retune_pending");
    tick(300);

    // aligned stop, then a stop cancelled by re-asserting run
    offer(24'h010000, 8'h00, 2'b01);
    wait_commit(600, "stop_cfg");
    wait_phase(8'h10, 300, "stop_align");
    bus.run = 1'b0;
    wait_idle(400, "stop_idle");
    check(bus.en_out === 1'b0, "stop_en_low");
    check(bus.phase_out === 8'h00, "stop_phase_zero");
    tick(3);
    bus.run = 1'b1;
    wait_phase(8'h10, 300, "restop_align");
    bus.run = 1'b0;
    wait_phase(8'h80, 300, "restop_resume");
    bus.run = 1'b1;
    tick(300);

    // zero tuning word: constant phase, stop one edge after STOPPING
    bus.run = 1'b0;
    wait_idle(600, "zero_ftw_prep");
    offer(24'h000000, 8'h33, 2'b00);
    tick(2);
    bus.run = 1'b1;
    tick(10);
    bus.run = 1'b0;
    tick(5);

    // reset mid-run with pending configuration discards the shadow
    offer(24'h040000, 8'h05, 2'b01);
    tick(2);
    bus.run = 1'b1;
    tick(20);
    offer(24'h008000, 8'h09, 2'b10);
    rst = 1'b1;
    tick();
    check(bus.en_out === 1'b0, "midrun_reset_en");
    check(bus.cfg_ready === 1'b1, "midrun_reset_ready");
    rst = 1'b0;
    tick(10);
    bus.run = 1'b0;
    tick(5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) bus.run = ~bus.run;
      bus.cfg_valid  = ($urandom_range(0, 7) == 0);
      bus.cfg_ftw    = ($urandom_range(0, 19) == 0) ? 24'h0 : 24'($urandom() >> (8 + $urandom_range(0, 5)));
      bus.cfg_poff   = 8'($urandom());
      bus.cfg_select = 2'($urandom());
      tick();
    end
    rst           = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.run       = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_accumulator.md
# phase_accumulator

DDS phase generator that drives the waveform lookup stage's `phase_in`, `en` and `select` inputs. An accumulator advances by a frequency tuning word (FTW) each cycle, and its top bits plus a phase offset form the 8-bit lookup phase. New configuration is buffered in a shadow register and committed only at a phase wrap, so frequency, offset and waveform changes never truncate a period. Start and stop requests are likewise aligned to period boundaries.

## Interface
- `ACC_W`, default 24: accumulator width. Legal range 8..32 and ≥ `PHASE_W`.
- `PHASE_W`, default 8: output phase width. Fixed to the lookup stage address width.
- `clk` in, 1: the only clock.
- `rst` in, 1: synchronous, active-high reset.
- `run` in, 1: level. 1 requests generation; 0 requests a stop at the next wrap.
- `cfg_valid` in, 1: configuration offer.
- `cfg_ready` out, 1: shadow register empty. Transfer occurs when `cfg_valid & cfg_ready` at a rising edge.
- `cfg_ftw` in, `ACC_W`: tuning word. f_out = ftw·f_clk / 2^ACC_W.
- `cfg_poff` in, `PHASE_W`: phase offset.
- `cfg_select` in, 2: waveform code passed through to the lookup stage.
- `phase_out` out, `PHASE_W`: lookup address.
- `en_out` out, 1: lookup enable.
- `select_out` out, 2: active waveform code.
- `wrap_pulse` out, 1: one-cycle strobe on the first cycle of each new period.

## Operation
- Registers:
  - `acc` (`ACC_W` bits).
  - Active set: `ftw_a`, `poff_a`, `sel_a`.
  - Shadow set plus a `pending` flag.
  - State register.
- `cfg_ready = ~pending`. On transfer the shadow loads and `pending` is set to 1.
- `phase_out = (acc[ACC_W-1 -: PHASE_W] + poff_a) mod 2^PHASE_W` while `en_out` = 1; otherwise 0.
- `phase_out` is driven only from registers; there is no input-to-output combinational path.
- `select_out = sel_a` at all times.
- Accumulator update: `{carry, acc_next} = acc + ftw_a`, truncated to `ACC_W` bits. `wrap` = carry.
- Commit: when `pending` is set, the active set loads from the shadow and `pending` clears on:
  - any edge in IDLE;
  - a `wrap` edge in RUN or STOPPING.
- States:
  - IDLE: `acc` held 0, `en_out` 0.
    - `run` = 1 → RUN, with `acc` = 0.
  - RUN: `acc` ← `acc_next` every cycle, `en_out` 1.
    - `run` = 0 → STOPPING.
  - STOPPING: accumulates as in RUN, `en_out` 1.
    - `run` = 1 → RUN, with no gap in phase.
    - `wrap` edge → IDLE, `acc` ← 0.
    - `ftw_a` == 0 → IDLE on the next edge, since it would otherwise never wrap.
- Simultaneous events:
  - A transfer and a wrap cannot coincide with a pending commit, because `cfg_ready` is 0 while `pending` = 1.
  - If `pending` = 0 at a wrap edge, a transfer on that edge lands in the shadow and commits at the following wrap.
  - In IDLE, a commit and `run` = 1 on the same edge: RUN starts with the new set.
- `rst`: `acc`, state, active set, shadow and `pending` all clear on the edge. Any pending configuration is discarded.

## Timing
- Reset values:
  - `phase_out` 0, `en_out` 0, `select_out` 0, `wrap_pulse` 0.
  - `cfg_ready` 1.
  - State IDLE, `ftw_a` 0, `poff_a` 0.
- Start: `run` sampled 1 at edge E in IDLE.
  - From E+1: `en_out` 1 and `phase_out` = `poff_a`.
  - `phase_out` reflects `acc` = k·`ftw_a` at E+1+k.
- Wrap at edge W (carry):
  - `wrap_pulse` 1 during the cycle after W.
  - The new `poff_a`/`sel_a` are visible in that same cycle.
  - The new `ftw_a` is used from the addition at W+1 onward.
- Configuration in IDLE: accepted at E, committed at E+1, `cfg_ready` 1 again after E+1.
- Stop: at the wrap edge W in STOPPING, after W:
  - `en_out` 0, `phase_out` 0;
  - `wrap_pulse` 1 for one cycle;
  - `select_out` = the committed value.
- The lookup stage adds its own latency; this block does not compensate for it.

## Test plan
1. Reset: hold `rst` 2 cycles with `run` = 1 and `cfg_valid` = 1 → after release: `phase_out` 0, `en_out` 0, `select_out` 0, `wrap_pulse` 0, `cfg_ready` 1, and no transfer during reset.
2. Basic run: `ACC_W` = 24; in IDLE configure `ftw` = 0x010000, `poff` = 0, `select` = 2'b11; then `run` = 1 → `phase_out` goes 0,1,…,255,0 with `en_out` 1 from the first RUN cycle, `wrap_pulse` every 256 cycles, `select_out` = 11.
3. Retune mid-period: at `phase_out` 0x40, offer `ftw` = 0x020000, `poff` = 0x80, `select` = 2'b10 → `cfg_ready` 0; phase keeps stepping +1 to 0xFF; in the wrap cycle `phase_out` = 0x80 and `select_out` = 10; subsequent steps are +2; `cfg_ready` returns to 1.
4. Aligned stop: `run` = 0 at `phase_out` 0x10 → continues to 0xFF; after the wrap: `en_out` 0, `phase_out` 0, one `wrap_pulse`. A repeat with `run` re-asserted at 0x80 in STOPPING → no interruption.
5. Zero FTW: configure `ftw` = 0, run, then drop `run` → `phase_out` constant at `poff`; IDLE and `en_out` 0 one edge after entering STOPPING.
6. Reset mid-run with pending configuration → next cycle all outputs are at reset values, `cfg_ready` 1, and a restart uses `ftw` 0 (the shadow was discarded).
